// File: rtl/onchip_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_ram_arbiter_if
//  Description : Avalon-MM style master bus bundle for one RAM client.
//                The master modport drives the request strobes, address
//                and write data. The slave modport (the arbiter side)
//                returns waitrequest, readdata and readdatavalid.
//  Signals     : address, byteenable, read, write, writedata   (master -> slave)
//                waitrequest, readdata, readdatavalid          (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface onchip_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/onchip_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_ram_arbiter
//  Description : Two-master round-robin arbiter in front of a single-port
//                on-chip RAM with fixed read latency. One transaction is
//                issued per clock; the losing master is held off with
//                waitrequest, and read data is steered back to the issuing
//                master through a {valid, id} tag pipeline.
//  Ports       : clk            system clock, rising edge
//                reset_n        asynchronous active-low reset
//                m0, m1         master buses (slave modport)
//                mem_address    RAM word address
//                mem_byteenable RAM byte lanes (all ones on reads)
//                mem_chipselect a transaction is issued this cycle
//                mem_write      issued transaction is a write
//                mem_writedata  RAM write data
//                mem_clken      RAM clock enable (low while in reset)
//                mem_readdata   RAM q
//  Parameters  : ADDR_W, DATA_W, READ_LATENCY (legal range 1..3)
//  Revision    : 1.0  initial release
// ============================================================================
module onchip_ram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  wire                   clk,
    input  wire                   reset_n,
    onchip_ram_arbiter_if.slave   m0,
    onchip_ram_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  wire  [DATA_W-1:0]     mem_readdata
);

    localparam int c_last_stage = READ_LATENCY - 1;

    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_issue_rd;

    // Id of the most recently granted master; the other one wins a tie.
    logic r_last;

    // Read-tag pipeline, one bit per stage: valid and master id.
    logic [READ_LATENCY-1:0] r_tag_vld;
    logic [READ_LATENCY-1:0] r_tag_id;

    // ------------------------------------------------------------------
    // Combinational grant. Gated by reset_n so nothing is issued while
    // the block is held in reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_req0     = m0.read | m0.write;
        w_req1     = m1.read | m1.write;
        w_gnt0     = reset_n & w_req0 & (~w_req1 | r_last);
        w_gnt1     = reset_n & w_req1 & (~w_req0 | ~r_last);
        // A simultaneous read+write strobe counts as a write: no response.
        w_issue_rd = (w_gnt0 & m0.read & ~m0.write) |
                     (w_gnt1 & m1.read & ~m1.write);
    end

    // ------------------------------------------------------------------
    // Memory port mux. m0 is the default source when nobody is granted.
    // ------------------------------------------------------------------
    always_comb begin
        mem_address    = m0.address;
        mem_writedata  = m0.writedata;
        mem_byteenable = m0.byteenable;
        mem_write      = 1'b0;
        if (w_gnt1) begin
            mem_address    = m1.address;
            mem_writedata  = m1.writedata;
            mem_byteenable = m1.byteenable;
            mem_write      = m1.write;
        end else if (w_gnt0) begin
            mem_write      = m0.write;
        end
        if ((w_gnt0 | w_gnt1) && !mem_write) begin
            mem_byteenable = '1;
        end
        mem_chipselect = w_gnt0 | w_gnt1;
        mem_clken      = reset_n;
    end

    // ------------------------------------------------------------------
    // Round-robin state and read-tag pipeline. Reset drops in-flight
    // reads so no stale readdatavalid ever emerges.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last    <= 1'b1;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
            r_tag_vld[0] <= w_issue_rd;
            r_tag_id[0]  <= w_gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Master-side responses. waitrequest is forced high during reset and
    // depends only on requests, grant and reset (never on mem_readdata).
    // ------------------------------------------------------------------
    assign m0.waitrequest   = ~reset_n | (w_req0 & ~w_gnt0);
    assign m1.waitrequest   = ~reset_n | (w_req1 & ~w_gnt1);
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = r_tag_vld[c_last_stage] & ~r_tag_id[c_last_stage];
    assign m1.readdatavalid = r_tag_vld[c_last_stage] &  r_tag_id[c_last_stage];

endmodule
`default_nettype wire

// File: tb/tb_onchip_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onchip_ram_arbiter
//  Description : Self-checking bench for onchip_ram_arbiter. Two instances:
//                dut_a with READ_LATENCY=1 and dut_b with READ_LATENCY=3,
//                each in front of a behavioural RAM. Accepted reads push
//                {master, data, due cycle} into a per-instance scoreboard;
//                every readdatavalid pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_onchip_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    onchip_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
    onchip_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
    onchip_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    onchip_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    logic [AW-1:0] a_addr, b_addr;
    logic [3:0]    a_be, b_be;
    logic          a_cs, b_cs, a_we, b_we, a_clken, b_clken;
    logic [DW-1:0] a_wd, b_wd, a_q, b_q, b_p1, b_p2;

    onchip_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .m0(a0), .m1(a1),
        .mem_address(a_addr), .mem_byteenable(a_be), .mem_chipselect(a_cs),
        .mem_write(a_we), .mem_writedata(a_wd), .mem_clken(a_clken),
        .mem_readdata(a_q)
    );

    onchip_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .m0(b0), .m1(b1),
        .mem_address(b_addr), .mem_byteenable(b_be), .mem_chipselect(b_cs),
        .mem_write(b_we), .mem_writedata(b_wd), .mem_clken(b_clken),
        .mem_readdata(b_q)
    );

    // Behavioural RAMs: write commits at the edge, reads registered.
    logic [31:0] ram_a [0:4095];
    logic [31:0] ram_b [0:4095];
    logic [31:0] shd_a [0:4095];
    logic [31:0] shd_b [0:4095];

    always @(posedge clk) begin
        if (a_cs && a_we)
            for (int i = 0; i < 4; i++)
                if (a_be[i]) ram_a[a_addr][8*i +: 8] <= a_wd[8*i +: 8];
        a_q <= ram_a[a_addr];
    end

    always @(posedge clk) begin
        if (b_cs && b_we)
            for (int i = 0; i < 4; i++)
                if (b_be[i]) ram_b[b_addr][8*i +: 8] <= b_wd[8*i +: 8];
        b_p1 <= ram_b[b_addr];
        b_p2 <= b_p1;
        b_q  <= b_p2;
    end

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [31:0] init_word(int a);
        if (a == 12'h010) return 32'hDEADBEEF;
        if (a == 12'h020) return 32'hAAAAAAAA;
        return 32'h5A000000 ^ (a * 32'h00010003);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(int d, int m, bit rd, bit wr, logic [11:0] ad,
                         logic [31:0] wd, logic [3:0] be);
        case ({d[0], m[0]})
            2'b00: begin a0.read = rd; a0.write = wr; a0.address = ad; a0.writedata = wd; a0.byteenable = be; end
            2'b01: begin a1.read = rd; a1.write = wr; a1.address = ad; a1.writedata = wd; a1.byteenable = be; end
            2'b10: begin b0.read = rd; b0.write = wr; b0.address = ad; b0.writedata = wd; b0.byteenable = be; end
            default: begin b1.read = rd; b1.write = wr; b1.address = ad; b1.writedata = wd; b1.byteenable = be; end
        endcase
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++)
                set_m(d, m, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    endtask

    // Record an accepted transaction in the shadow memory / scoreboard.
    task automatic acc(int d, bit m, bit rd, bit wr, logic [11:0] ad,
                       logic [31:0] wd, logic [3:0] be);
        exp_t e;
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) begin
                    if (d == 0) shd_a[ad][8*i +: 8] = wd[8*i +: 8];
                    else        shd_b[ad][8*i +: 8] = wd[8*i +: 8];
                end
        end else if (rd) begin
            e.id = m;
            if (d == 0) begin
                e.data = shd_a[ad]; e.due = cyc + 1; q_a.push_back(e);
            end else begin
                e.data = shd_b[ad]; e.due = cyc + 3; q_b.push_back(e);
            end
        end
    endtask

    task automatic track();
        if ((a0.read | a0.write) && !a0.waitrequest) acc(0, 1'b0, a0.read, a0.write, a0.address, a0.writedata, a0.byteenable);
        if ((a1.read | a1.write) && !a1.waitrequest) acc(0, 1'b1, a1.read, a1.write, a1.address, a1.writedata, a1.byteenable);
        if ((b0.read | b0.write) && !b0.waitrequest) acc(1, 1'b0, b0.read, b0.write, b0.address, b0.writedata, b0.byteenable);
        if ((b1.read | b1.write) && !b1.waitrequest) acc(1, 1'b1, b1.read, b1.write, b1.address, b1.writedata, b1.byteenable);
    endtask

    task automatic mon_one(int d, string nm, logic v0, logic v1,
                           logic [31:0] rd0, logic [31:0] rd1);
        exp_t e;
        int   n;
        n = (d == 0) ? q_a.size() : q_b.size();
        if (v0 | v1) begin
            if (n == 0) begin
                chk($sformatf("%s_spurious_valid", nm), {v1, v0}, 2'b00);
            end else begin
                if (d == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                chk($sformatf("%s_valid_tag", nm), {v1, v0}, 2'b01 << e.id);
                chk($sformatf("%s_latency", nm), cyc, e.due);
                chk($sformatf("%s_rdata", nm), e.id ? rd1 : rd0, e.data);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon_one(0, "A", a0.readdatavalid, a1.readdatavalid, a0.readdata, a1.readdata);
        mon_one(1, "B", b0.readdatavalid, b1.readdatavalid, b0.readdata, b1.readdata);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic cyc_end();
        track();
        step();
    endtask

    task automatic drain(int n);
        idle();
        repeat (n) begin
            #1;
            cyc_end();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1;
        for (int i = 0; i < 4096; i++) begin
            ram_a[i] = init_word(i); shd_a[i] = init_word(i);
            ram_b[i] = init_word(i); shd_b[i] = init_word(i);
        end
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        idle();

        // Reset held 3 cycles with all masters requesting.
        set_m(0, 0, 1'b1, 1'b0, 12'h000, 32'h0, 4'hF);
        set_m(0, 1, 1'b1, 1'b0, 12'h100, 32'h0, 4'hF);
        set_m(1, 0, 1'b1, 1'b0, 12'h000, 32'h0, 4'hF);
        set_m(1, 1, 1'b1, 1'b0, 12'h100, 32'h0, 4'hF);
        repeat (3) begin
            #1;
            chk("rst_a_wait0", a0.waitrequest, 1'b1);
            chk("rst_a_wait1", a1.waitrequest, 1'b1);
            chk("rst_a_cs", a_cs, 1'b0);
            chk("rst_a_we", a_we, 1'b0);
            chk("rst_a_clken", a_clken, 1'b0);
            chk("rst_b_wait0", b0.waitrequest, 1'b1);
            chk("rst_b_cs", b_cs, 1'b0);
            chk("rst_b_valid", {b1.readdatavalid, b0.readdatavalid}, 2'b00);
            cyc_end();
        end
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        #1;
        chk("post_rst_a_wait0", a0.waitrequest, 1'b0);
        chk("post_rst_a_wait1", a1.waitrequest, 1'b1);
        chk("post_rst_a_cs", a_cs, 1'b1);
        chk("post_rst_a_clken", a_clken, 1'b1);
        chk("post_rst_b_wait0", b0.waitrequest, 1'b0);
        chk("post_rst_b_wait1", b1.waitrequest, 1'b1);
        cyc_end();
        set_m(0, 0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        set_m(1, 0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("post_rst_a_wait1_next", a1.waitrequest, 1'b0);
        chk("post_rst_b_wait1_next", b1.waitrequest, 1'b0);
        cyc_end();
        drain(4);

        // Single read of 0x010 by m0 on dut_a.
        set_m(0, 0, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        #1;
        chk("single_wait0", a0.waitrequest, 1'b0);
        chk("single_addr", a_addr, 12'h010);
        cyc_end();
        drain(2);

        // Byte-masked write by m1 then read back.
        set_m(0, 1, 1'b0, 1'b1, 12'h020, 32'h11223344, 4'b0101);
        #1;
        chk("bytewr_wait1", a1.waitrequest, 1'b0);
        chk("bytewr_we", a_we, 1'b1);
        chk("bytewr_be", a_be, 4'b0101);
        cyc_end();
        set_m(0, 1, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        #1;
        chk("byterd_wait1", a1.waitrequest, 1'b0);
        chk("byterd_be_ones", a_be, 4'hF);
        chk("byterd_we", a_we, 1'b0);
        chk("bytewr_shadow", shd_a[12'h020], 32'hAA22AA44);
        cyc_end();
        drain(2);

        // Continuous contention: strict alternation starting with m0.
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 8; k++) begin
            set_m(0, 0, i0 < 4, 1'b0, 12'(i0), 32'h0, 4'hF);
            set_m(0, 1, i1 < 4, 1'b0, 12'(12'h100 + i1), 32'h0, 4'hF);
            #1;
            chk($sformatf("cont%0d_wait0", k), a0.waitrequest, (i0 < 4) && k[0]);
            chk($sformatf("cont%0d_wait1", k), a1.waitrequest, (i1 < 4) && !k[0]);
            chk($sformatf("cont%0d_addr", k), a_addr, k[0] ? 12'(12'h100 + i1) : 12'(i0));
            cyc_end();
            if (k[0]) i1++;
            else      i0++;
        end
        drain(2);

        // Reset asserted asynchronously in the accept cycle of an m0 read.
        set_m(0, 0, 1'b1, 1'b0, 12'h001, 32'h0, 4'hF);
        #1;
        chk("rstmid_a_wait0", a0.waitrequest, 1'b0);
        #1;
        rst_a_n = 1'b0;
        #1;
        chk("rstmid_a_wait_forced", a0.waitrequest, 1'b1);
        chk("rstmid_a_cs", a_cs, 1'b0);
        chk("rstmid_a_clken", a_clken, 1'b0);
        idle();
        step();
        rst_a_n = 1'b1;
        drain(4);

        // Reset while an m0 read is inside the 3-deep pipeline of dut_b.
        set_m(1, 0, 1'b1, 1'b0, 12'h005, 32'h0, 4'hF);
        #1;
        chk("rstmid_b_wait0", b0.waitrequest, 1'b0);
        cyc_end();
        idle();
        #1;
        rst_b_n = 1'b0;
        q_b.delete();
        #1;
        chk("rstmid_b_wait_forced", b0.waitrequest, 1'b1);
        step();
        rst_b_n = 1'b1;
        drain(5);

        // dut_b write then read the same word in consecutive cycles.
        set_m(1, 0, 1'b0, 1'b1, 12'h300, 32'hCAFEF00D, 4'hF);
        #1;
        chk("wr_rd_b_wait_wr", b0.waitrequest, 1'b0);
        cyc_end();
        set_m(1, 0, 1'b1, 1'b0, 12'h300, 32'h0, 4'hF);
        #1;
        chk("wr_rd_b_wait_rd", b0.waitrequest, 1'b0);
        cyc_end();
        drain(4);

        // Five back-to-back m1 reads through the 3-cycle pipeline.
        for (int k = 0; k < 5; k++) begin
            set_m(1, 1, 1'b1, 1'b0, 12'(12'h200 + k), 32'h0, 4'hF);
            #1;
            chk($sformatf("b2b_wait1_%0d", k), b1.waitrequest, 1'b0);
            cyc_end();
        end
        drain(5);

        chk("A_drained", q_a.size(), 0);
        chk("B_drained", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/onchip_ram_arbiter.md
# onchip_ram_arbiter

Two-master round-robin arbiter that shares the single-port on-chip RAM (32-bit words, 12-bit word address, byte enables, fixed read latency) between the Nios II data master (m0) and a streaming DMA/video master (m1). It sits between the two Avalon-MM masters and the RAM's s1 port. It accepts one transaction per clock, stalls the losing master with waitrequest, and routes pipelined read data back to the issuing master.

## Interface
- ADDR_W, 12, word address width (RAM depth up to 2^ADDR_W words)
- DATA_W, 32, data width; byteenable width = DATA_W/8
- READ_LATENCY, 1, RAM clocks from accepted read to valid data; legal range 1..3
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
- mN_address  in  ADDR_W  word address, master N (N = 0, 1)
- mN_byteenable  in  DATA_W/8  byte lanes for writes; ignored for reads
- mN_read / mN_write  in  1  request strobes, held until accepted
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data (mem_readdata broadcast to both masters)
- mN_readdatavalid  out  1  one-cycle pulse per accepted read of master N
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable; all-ones on reads
- mem_chipselect  out  1  high in any cycle a transaction is issued
- mem_write  out  1  high when the issued transaction is a write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  RAM clock enable; 0 while reset_n is low, else 1
- mem_readdata  in  DATA_W  from RAM q

## Operation
- reqN = mN_read | mN_write. If both strobes are high, the transaction is a write and returns no readdatavalid.
- Grant is combinational, decided in the same cycle as the request:
  - Only one master requesting: that master wins.
  - Both requesting: the master that is not `last` wins.
- `last` register: reset value 1, so m0 wins the first contention. Updated to the granted id on every grant.
- mN_waitrequest = reqN & ~grantN. It is low when the master is idle. Both waitrequests are forced to 1 while reset_n is low.
- Memory port mux: mem_address, mem_writedata and mem_byteenable come from the granted master. mem_chipselect = grant0 | grant1. mem_write = the granted master's write strobe.
- With no grant, mem_chipselect = 0 and mem_write = 0. Address and data outputs are don't-care but driven from m0.
- Read-tag pipeline: a shift register of READ_LATENCY stages, each stage holding {valid, id}.
  - Stage 0 loads {granted read, granted id}.
  - The final stage drives mN_readdatavalid = valid & (id == N).
- Writes complete on acceptance and produce no response.
- Fairness: under continuous contention grants strictly alternate. A master waits at most 1 cycle.
- Reset mid-operation clears the tag pipeline and `last`. In-flight reads are dropped: no readdatavalid after reset, and none after release for reads issued before reset.
- Write-then-read to the same address in consecutive cycles returns the new data, because the RAM port commits the write before the next read.

## Timing
- Reset values:
  - mN_readdatavalid = 0
  - mem_chipselect = 0, mem_write = 0, mem_clken = 0
  - mN_waitrequest = 1
  - tag pipeline all invalid; `last` = 1
- Acceptance is zero-wait when uncontended: a request in cycle T with waitrequest low in T is accepted in T.
- Read data appears in cycle T+READ_LATENCY: mN_readdatavalid = 1 and mN_readdata is valid.
- Throughput: one transaction per clock aggregate. Back-to-back reads from one master produce back-to-back valids.
- Read responses return in issue order. No read is ever reordered or lost outside of reset.
- There is no combinational path from mem_readdata to any waitrequest.

## Test plan
- Reset: hold reset_n low 3 cycles with both masters requesting. Required: waitrequests = 1, chipselect = 0, no valids. After release, m0 is granted first.
- Single read: RAM word 0x010 = 0xDEADBEEF, m0 reads 0x010 in cycle T. Required: m0_waitrequest = 0 at T. At T+1, m0_readdatavalid = 1 and m0_readdata = 0xDEADBEEF. m1_readdatavalid stays 0.
- Byte write: m1 writes 0x11223344 to 0x020 with byteenable 0b0101 over initial 0xAAAAAAAA, then m1 reads 0x020. Required: readdata = 0xAA22AA44.
- Contention: both masters issue 4 reads each continuously (m0 to 0x000..0x003, m1 to 0x100..0x103). Required: grants alternate m0,m1,m0,m1,… over 8 consecutive cycles, each valid is tagged to the correct master, and the data matches.
- Reset mid-read: m0 read accepted at T, reset_n pulsed low at T (asynchronous). Required: no m0_readdatavalid at T+1 or later.
- Parameter READ_LATENCY = 3: 5 back-to-back m1 reads. Required: 5 consecutive valids starting 3 cycles after the first accept, in order.
